ram_wr_fifo: RTL and testbench
==============================

Name: ram_wr_fifo

Overview:
- Write-side front end that feeds the 64-bit x 4K dual-port RAM write port (data_in, wr_address, write).
- Accepts write requests from the system over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Drains the FIFO into the RAM at most one write per clock, unless the drain is stalled.
- Provides a read-after-write hazard flag so the read-side controller can hold a read whose address still has a pending write.

Parameters:
- RAM_WIDTH, 64, data width; matches the RAM data_in width.
- ADDR_SIZE, 12, address width; matches the RAM wr_address/rd_address width.
- DEPTH, 8, number of FIFO entries; must be a power of 2 and >= 2.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- req_valid  input  1  write request valid.
- req_ready  output  1  FIFO can accept a request.
- req_addr  input  ADDR_SIZE  request write address.
- req_data  input  RAM_WIDTH  request write data.
- stall  input  1  when 1, the FIFO does not drain this cycle.
- wr_address  output  ADDR_SIZE  RAM write address (registered).
- data_in  output  RAM_WIDTH  RAM write data (registered).
- write  output  1  RAM write strobe (registered).
- rd_address  input  ADDR_SIZE  address of the read currently being issued.
- hazard  output  1  rd_address matches a pending write.
- count  output  $clog2(DEPTH)+1  number of occupied FIFO entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.

Behaviour:
- Reset (resetn low, asynchronous):
  - Read/write pointers = 0; count = 0; empty = 1; full = 0; req_ready = 1.
  - write = 0; wr_address = 0; data_in = 0.
  - FIFO storage contents are don't-care.
  - Reset asserted mid-operation discards all pending entries and any write in flight. write drops immediately and asynchronously.
- Push:
  - Occurs at a rising edge when req_valid && req_ready.
  - Stores {req_addr, req_data} at the write pointer; write pointer increments, wrapping modulo DEPTH.
- Ready and stalled requests:
  - req_ready = !full, combinational from count only; it does not depend on req_valid or on a pop in the same cycle.
  - While full, no push occurs even if a pop happens in the same cycle.
  - If req_valid is high while req_ready is low, nothing is accepted. The requester holds addr/data stable until accepted.
- Pop:
  - Occurs at a rising edge when !empty && !stall.
  - The head entry loads into wr_address/data_in, write is set to 1, and the read pointer increments modulo DEPTH.
  - At any edge without a pop, write goes to 0 and wr_address/data_in hold their last values.
  - write is therefore high for exactly one cycle per drained entry, and high continuously on back-to-back pops.
- Latency:
  - A request accepted at edge N into an empty, unstalled FIFO pops at edge N+1.
  - It is visible on write/wr_address/data_in during the cycle after edge N+1.
  - The RAM commits it at edge N+2.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Ordering: strict FIFO order, with no merging or reordering. Duplicate addresses are written in arrival order, so the last write wins in the RAM.
- Count, empty, full:
  - count updates registered: +1 on push only, -1 on pop only, unchanged on both or neither.
  - empty and full are decoded from count.
- Hazard (combinational) is 1 if either of the following holds:
  - rd_address equals the address of any occupied FIFO entry; or
  - write == 1 and rd_address == wr_address (the write is not yet committed by the RAM).
  - Unoccupied entries never contribute. hazard = 0 during reset.
- Stall:
  - stall held high freezes the read pointer and keeps write at 0.
  - Pushes continue until full.
  - Stall has no effect on an empty FIFO.

Test Plan:
- Reset, then one request addr=12'h005 data=64'hDEAD_BEEF_0000_0001 at edge N -> write=1 with wr_address=12'h005 and that data_in for exactly the cycle after edge N+1; count back to 0; empty=1.
- With stall=1, push 8 requests (addr 0..7, data = addr) -> full=1, req_ready=0, count=8; a 9th req_valid is not accepted. Release stall -> 8 consecutive write pulses with addresses 0..7 in order; req_ready returns 1 after the first pop.
- Continuous req_valid with stall=0 at one request per clock (addr 0x100..0x10F) -> count stays at most 1; 16 back-to-back write cycles; pointers wrap past DEPTH with no loss or reorder.
- Queue addr 12'hABC (stalled), drive rd_address=12'hABC -> hazard=1; release stall -> hazard stays 1 while write=1 with wr_address=12'hABC, then 0 on the next cycle. rd_address=12'hABD -> hazard=0 throughout.
- Fill 5 entries, then assert resetn=0 mid-drain -> write=0 immediately, count=0, empty=1, hazard=0; after deassertion, no stale write occurs.
- Push two writes to addr 12'h010 (data 1, then 2) -> RAM receives data 1 then data 2 on consecutive write pulses, in that order.

Source files
------------

// File: rtl/ram_wr_fifo.sv
// Write-side front end for a 64-bit x 4K dual-port RAM: buffers valid/ready write
// requests in a small FIFO, drains one per clock, and flags read-after-write hazards.
module ram_wr_fifo #(
  parameter int RAM_WIDTH = 64,
  parameter int ADDR_SIZE = 12,
  parameter int DEPTH     = 8
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_SIZE-1:0]     req_addr,
  input  logic [RAM_WIDTH-1:0]     req_data,
  input  logic                     stall,
  output logic [ADDR_SIZE-1:0]     wr_address,
  output logic [RAM_WIDTH-1:0]     data_in,
  output logic                     write,
  input  logic [ADDR_SIZE-1:0]     rd_address,
  output logic                     hazard,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_SIZE-1:0] r_mem_addr [DEPTH];
  logic [RAM_WIDTH-1:0] r_mem_data [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_write;
  logic [ADDR_SIZE-1:0] r_wr_address;
  logic [RAM_WIDTH-1:0] r_data_in;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_hazard;
  logic [PTR_W-1:0]     w_offset;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  // Ready looks at occupancy only, so a full FIFO refuses a push even when it pops.
  assign w_push  = req_valid && !w_full;
  assign w_pop   = !w_empty && !stall;

  // NOTE: storage has no reset; occupancy is tracked by the pointers and count,
  // so stale contents are never observed and the array can map onto plain RAM cells.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= req_addr;
      r_mem_data[r_wr_ptr] <= req_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_write      <= 1'b0;
      r_wr_address <= '0;
      r_data_in    <= '0;
    end else begin
      r_write <= w_pop;
      if (w_pop) begin
        r_wr_address <= r_mem_addr[r_rd_ptr];
        r_data_in    <= r_mem_data[r_rd_ptr];
      end
    end
  end

  // An entry is occupied when its distance from the read pointer is below count.
  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    w_hazard = r_write && (rd_address == r_wr_address);
    w_offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_offset = PTR_W'(i) - r_rd_ptr;
      if (({1'b0, w_offset} < r_count) && (r_mem_addr[i] == rd_address))
        w_hazard = 1'b1;
    end
  end

  assign req_ready  = !w_full;
  assign empty      = w_empty;
  assign full       = w_full;
  assign count      = r_count;
  assign write      = r_write;
  assign wr_address = r_wr_address;
  assign data_in    = r_data_in;
  assign hazard     = w_hazard;

endmodule

// File: tb/tb_ram_wr_fifo.sv
// Self-checking bench for ram_wr_fifo: table vectors, directed corner sequences and
// random traffic compared every cycle against a queue-based reference model.
module tb_ram_wr_fifo;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic [63:0] req_data;
  logic        stall;
  logic [11:0] wr_address;
  logic [63:0] data_in;
  logic        write;
  logic [11:0] rd_address;
  logic        hazard;
  logic [3:0]  count;
  logic        empty;
  logic        full;

  ram_wr_fifo #(.RAM_WIDTH(64), .ADDR_SIZE(12), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .stall      (stall),
    .wr_address (wr_address),
    .data_in    (data_in),
    .write      (write),
    .rd_address (rd_address),
    .hazard     (hazard),
    .count      (count),
    .empty      (empty),
    .full       (full)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: pending writes as a queue plus the last drained write.
  typedef struct { logic [11:0] addr; logic [63:0] data; } entry_t;
  entry_t      q[$];
  logic        m_write;
  logic [11:0] m_waddr;
  logic [63:0] m_data;

  function automatic logic m_hazard();
    logic h;
    h = m_write && (m_waddr == rd_address);
    foreach (q[i]) if (q[i].addr == rd_address) h = 1'b1;
    return h;
  endfunction

  task automatic model_check();
    check("m_count",  64'(count), 64'(q.size()));
    check("m_empty",  64'(empty), 64'(q.size() == 0));
    check("m_full",   64'(full),  64'(q.size() == DEPTH));
    check("m_ready",  64'(req_ready), 64'(q.size() < DEPTH));
    check("m_write",  64'(write), 64'(m_write));
    check("m_waddr",  64'(wr_address), 64'(m_waddr));
    check("m_data",   data_in, m_data);
    check("m_hazard", 64'(hazard), 64'(m_hazard()));
  endtask

  task automatic apply(input logic v, input logic [11:0] a, input logic [63:0] d,
                       input logic s, input logic [11:0] r);
    req_valid  = v;
    req_addr   = a;
    req_data   = d;
    stall      = s;
    rd_address = r;
    #1;
    model_check();
  endtask

  task automatic advance();
    bit     do_push, do_pop;
    entry_t e, n;
    do_push = req_valid && (q.size() < DEPTH);
    do_pop  = (q.size() != 0) && !stall;
    n.addr  = req_addr;
    n.data  = req_data;
    @(posedge clock);
    if (do_pop) begin
      e = q.pop_front();
      m_write = 1'b1;
      m_waddr = e.addr;
      m_data  = e.data;
    end else begin
      m_write = 1'b0;
    end
    if (do_push) q.push_back(n);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_write = 1'b0;
    m_waddr = '0;
    m_data  = '0;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    req_valid = 1'b0;
    stall     = 1'b0;
    model_reset();
    #2;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  typedef struct {
    logic        valid;
    logic [11:0] addr;
    logic [63:0] data;
    logic        stall;
    logic [11:0] rd;
    logic [3:0]  exp_count;
    logic        exp_write;
    logic [11:0] exp_waddr;
    logic [63:0] exp_data;
    logic        exp_hazard;
  } vec_t;

  vec_t tbl[$];

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      apply(tbl[i].valid, tbl[i].addr, tbl[i].data, tbl[i].stall, tbl[i].rd);
      check($sformatf("%s[%0d].count", tag, i),  64'(count),      64'(tbl[i].exp_count));
      check($sformatf("%s[%0d].write", tag, i),  64'(write),      64'(tbl[i].exp_write));
      check($sformatf("%s[%0d].waddr", tag, i),  64'(wr_address), 64'(tbl[i].exp_waddr));
      check($sformatf("%s[%0d].data", tag, i),   data_in,         tbl[i].exp_data);
      check($sformatf("%s[%0d].hazard", tag, i), 64'(hazard),     64'(tbl[i].exp_hazard));
      advance();
    end
    tbl.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [11:0] wq[$];
    logic [63:0] dq[$];
    int          run, run_max;
    logic        cv;
    logic [11:0] ca;
    logic [63:0] cd;

    resetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0;
    stall = 1'b0; rd_address = '0;
    model_reset();
    #3;
    check("rst.count", 64'(count), 0);
    check("rst.empty", 64'(empty), 1);
    check("rst.full",  64'(full), 0);
    check("rst.ready", 64'(req_ready), 1);
    check("rst.write", 64'(write), 0);
    check("rst.waddr", 64'(wr_address), 0);
    check("rst.data",  data_in, 0);
    check("rst.hazard", 64'(hazard), 0);
    @(negedge clock);
    resetn = 1'b1;

    // Single request latency: visible on write for exactly the cycle after edge N+1.
    tbl.push_back('{1'b1, 12'h005, 64'hDEAD_BEEF_0000_0001, 1'b0, 12'hFFF, 4'd0, 1'b0, 12'h000, 64'h0, 1'b0});
    tbl.push_back('{1'b0, 12'h000, 64'h0, 1'b0, 12'hFFF, 4'd1, 1'b0, 12'h000, 64'h0, 1'b0});
    tbl.push_back('{1'b0, 12'h000, 64'h0, 1'b0, 12'h005, 4'd0, 1'b1, 12'h005, 64'hDEAD_BEEF_0000_0001, 1'b1});
    tbl.push_back('{1'b0, 12'h000, 64'h0, 1'b0, 12'h005, 4'd0, 1'b0, 12'h005, 64'hDEAD_BEEF_0000_0001, 1'b0});
    run_table("single");

    // Hazard on a queued and then in-flight address.
    do_reset();
    tbl.push_back('{1'b1, 12'hABC, 64'h77, 1'b1, 12'hABC, 4'd0, 1'b0, 12'h000, 64'h0, 1'b0});
    tbl.push_back('{1'b0, 12'h000, 64'h0,  1'b1, 12'hABC, 4'd1, 1'b0, 12'h000, 64'h0, 1'b1});
    tbl.push_back('{1'b0, 12'h000, 64'h0,  1'b1, 12'hABD, 4'd1, 1'b0, 12'h000, 64'h0, 1'b0});
    tbl.push_back('{1'b0, 12'h000, 64'h0,  1'b0, 12'hABC, 4'd1, 1'b0, 12'h000, 64'h0, 1'b1});
    tbl.push_back('{1'b0, 12'h000, 64'h0,  1'b0, 12'hABC, 4'd0, 1'b1, 12'hABC, 64'h77, 1'b1});
    tbl.push_back('{1'b0, 12'h000, 64'h0,  1'b0, 12'hABC, 4'd0, 1'b0, 12'hABC, 64'h77, 1'b0});
    tbl.push_back('{1'b0, 12'h000, 64'h0,  1'b0, 12'hABD, 4'd0, 1'b0, 12'hABC, 64'h77, 1'b0});
    run_table("hazard");

    // Fill under stall, refuse a 9th request, then drain in order.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      apply(1'b1, 12'(i), 64'(i), 1'b1, 12'hFFF);
      advance();
    end
    for (int k = 0; k < 2; k++) begin
      apply(1'b1, 12'h099, 64'h99, 1'b1, 12'hFFF);
      check("full.full",  64'(full), 1);
      check("full.ready", 64'(req_ready), 0);
      check("full.count", 64'(count), 8);
      advance();
    end
    for (int k = 0; k <= DEPTH; k++) begin
      apply(1'b0, 12'h000, 64'h0, 1'b0, 12'hFFF);
      if (k > 0) begin
        check($sformatf("drain[%0d].write", k), 64'(write), 1);
        check($sformatf("drain[%0d].waddr", k), 64'(wr_address), 64'(k - 1));
      end
      if (k == 1) check("drain.ready_back", 64'(req_ready), 1);
      advance();
    end
    apply(1'b0, 12'h000, 64'h0, 1'b0, 12'hFFF);
    check("drain.end_write", 64'(write), 0);
    advance();

    // Streaming one request per clock, pointers wrap twice.
    do_reset();
    run = 0; run_max = 0;
    for (int i = 0; i < 19; i++) begin
      if (i < 16) apply(1'b1, 12'(12'h100 + i), 64'(i), 1'b0, 12'hFFF);
      else        apply(1'b0, 12'h000, 64'h0, 1'b0, 12'hFFF);
      check($sformatf("stream[%0d].count_le1", i), 64'(count <= 1), 1);
      advance();
      if (write) begin
        wq.push_back(wr_address);
        run++;
        if (run > run_max) run_max = run;
      end else run = 0;
    end
    check("stream.nwrites", 64'(wq.size()), 16);
    check("stream.b2b", 64'(run_max), 16);
    foreach (wq[i]) check($sformatf("stream.order[%0d]", i), 64'(wq[i]), 64'(12'h100 + i));
    wq.delete();

    // Reset in the middle of a drain.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 12'(12'h020 + i), 64'(i), 1'b1, 12'hFFF);
      advance();
    end
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 12'h000, 64'h0, 1'b0, 12'h024);
      advance();
    end
    rd_address = 12'h021;
    #1;
    check("mid.pre_write",  64'(write), 1);
    check("mid.pre_hazard", 64'(hazard), 1);
    resetn = 1'b0;
    model_reset();
    #1;
    check("mid.write",  64'(write), 0);
    check("mid.count",  64'(count), 0);
    check("mid.empty",  64'(empty), 1);
    check("mid.hazard", 64'(hazard), 0);
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 12'h000, 64'h0, 1'b0, 12'h024);
      check($sformatf("mid.after[%0d].write", i), 64'(write), 0);
      advance();
    end

    // Duplicate addresses drain in arrival order.
    do_reset();
    apply(1'b1, 12'h010, 64'd1, 1'b0, 12'hFFF); advance();
    apply(1'b1, 12'h010, 64'd2, 1'b0, 12'hFFF); advance();
    for (int i = 0; i < 3; i++) begin
      if (write) begin wq.push_back(wr_address); dq.push_back(data_in); end
      apply(1'b0, 12'h000, 64'h0, 1'b0, 12'hFFF); advance();
    end
    check("dup.n", 64'(dq.size()), 2);
    if (dq.size() == 2) begin
      check("dup.first",  dq[0], 64'd1);
      check("dup.second", dq[1], 64'd2);
      check("dup.addr0",  64'(wq[0]), 64'h010);
      check("dup.addr1",  64'(wq[1]), 64'h010);
    end

    // Random traffic against the model; requester holds a refused request.
    do_reset();
    cv = 1'b0; ca = '0; cd = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!(cv && q.size() >= DEPTH)) begin
        cv = ($urandom_range(0, 99) < 60);
        ca = 12'($urandom_range(0, 15));
        cd = {$urandom, $urandom};
      end
      apply(cv, ca, cd, ($urandom_range(0, 99) < 35), 12'($urandom_range(0, 15)));
      advance();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
